bloom_filter_ctrl: RTL and testbench



---
 rtl/bloom_pkg.sv | 22 ++
 rtl/and_gate_condense.sv | 15 +
 rtl/bloom_filter_ctrl.sv | 143 ++++++++++++++
 tb/tb_bloom_filter_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// bloom_pkg
// Shared definitions for the Bloom filter controller slice.
//   - controller state encodings (2-bit constants)
//   - request opcode constants (query / insert)
//   - idx_width(): counter/index width helper that never returns 0
package bloom_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PROBE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic OP_QUERY  = 1'b0;
    localparam logic OP_INSERT = 1'b1;

    // Width needed to address n items; a single item still needs one bit
    // so that counters never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/and_gate_condense.sv
// and_gate_condense
// Generic n-input AND reduction from the gate library.
// Ports:
//   a : n-bit input vector
//   y : 1 when every bit of a is 1
module and_gate_condense #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    output logic         y
);

    assign y = &a;

endmodule

// File: rtl/bloom_filter_ctrl.sv
// bloom_filter_ctrl
// Sequencing controller for a single-port Bloom filter bit array. Accepts
// query/insert requests carrying K hash indices, probes (and for inserts
// sets) one bit per cycle, then returns the AND of the probed bits as a
// membership verdict over a valid/ready response channel. Also owns clearing.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid/ready/op/idx : request channel (idx i at [i*IDX_W +: IDX_W])
//   clear         : level request to zero the filter
//   rsp_valid/ready/hit    : verdict channel (registered outputs)
//   busy          : controller not idle or a clear is pending
//   insert_count  : saturating count of accepted inserts since last clear
module bloom_filter_ctrl
    import bloom_pkg::*;
#(
    parameter int M     = 256,
    parameter int K     = 4,
    parameter int IDX_W = $clog2(M),
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [K*IDX_W-1:0] req_idx,
    input  logic               clear,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic               busy,
    output logic [CNT_W-1:0]   insert_count
);

    localparam int              CW    = idx_width(K);
    localparam logic [CW-1:0]   LAST  = CW'(K - 1);
    localparam logic [IDX_W:0]  M_LIM = (IDX_W + 1)'(M);

    logic [1:0]         state;
    logic [M-1:0]       bits;
    logic [K-1:0]       probe;
    logic [K-1:0]       probe_next;
    logic [CW-1:0]      cnt;
    logic               op;
    logic [K*IDX_W-1:0] idx;
    logic               clr_pend;
    logic [IDX_W-1:0]   cur_idx;
    logic               in_range;
    logic               probe_bit;
    logic               hit_next;

    assign cur_idx   = idx[int'(cnt)*IDX_W +: IDX_W];

    // Indices at or beyond M (possible when M is not a power of two)
    // read as 0 and are never written.
    assign in_range  = ({1'b0, cur_idx} < M_LIM);
    assign probe_bit = in_range && bits[cur_idx];

    // The verdict is reduced from the probe vector including the bit being
    // probed this cycle, so rsp_hit can be registered on the last probe edge.
    always_comb begin
        probe_next      = probe;
        probe_next[cnt] = probe_bit;
    end

    and_gate_condense #(.n(K)) u_reduce (
        .a (probe_next),
        .y (hit_next)
    );

    assign req_ready = (state == ST_IDLE) && !clear && !clr_pend;
    assign busy      = (state != ST_IDLE) || clr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bits         <= '0;
            probe        <= '0;
            cnt          <= '0;
            op           <= OP_QUERY;
            idx          <= '0;
            clr_pend     <= 1'b0;
            insert_count <= '0;
            rsp_valid    <= 1'b0;
            rsp_hit      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // clear wins over a simultaneous request
                    if (clear || clr_pend) begin
                        state <= ST_CLEAR;
                    end else if (req_valid) begin
                        op    <= req_op;
                        idx   <= req_idx;
                        probe <= '0;
                        cnt   <= '0;
                        state <= ST_PROBE;
                        if (req_op == OP_INSERT && insert_count != '1) begin
                            insert_count <= insert_count + 1'b1;
                        end
                    end
                end
                ST_PROBE: begin
                    // A write here is seen by the next probe, so duplicate
                    // indices within one insert read back as set.
                    probe <= probe_next;
                    if (op == OP_INSERT && in_range) begin
                        bits[cur_idx] <= 1'b1;
                    end
                    if (cnt == LAST) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= hit_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    if (clear) begin
                        clr_pend <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (clear) begin
                        clr_pend <= 1'b1;
                    end
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= clr_pend ? ST_CLEAR : ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    bits         <= '0;
                    insert_count <= '0;
                    clr_pend     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_filter_ctrl.sv
// tb_bloom_filter_ctrl
// Directed bench for bloom_filter_ctrl. A bit-array model predicts each
// verdict when the request is driven; predictions queue up and are popped
// when the response appears. A narrow insert counter keeps the saturation
// run short.
module tb_bloom_filter_ctrl;
    import bloom_pkg::*;

    localparam int M     = 256;
    localparam int K     = 4;
    localparam int IDX_W = 8;
    localparam int CNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_op;
    logic [K*IDX_W-1:0] req_idx;
    logic               clear;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic               busy;
    logic [CNT_W-1:0]   insert_count;

    int   assert_count = 0;
    int   fail_count   = 0;
    logic exp_q[$];
    logic [M-1:0]     model_bits  = '0;
    logic [CNT_W-1:0] model_count = '0;

    bloom_filter_ctrl #(.M(M), .K(K), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_idx      (req_idx),
        .clear        (clear),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_hit      (rsp_hit),
        .busy         (busy),
        .insert_count (insert_count)
    );

    always #5 clk = ~clk;

    // Safety net in case a bounded wait is ever mis-sized.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [K*IDX_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {IDX_W'(d), IDX_W'(c), IDX_W'(b), IDX_W'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for req_ready, presents one request for exactly the accept edge,
    // and records the model's predicted verdict.
    task automatic send(input logic op, input logic [K*IDX_W-1:0] idx);
        int   guard;
        logic hit;
        int   ix;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
        end
        check("req_ready_wait", 32'(guard < 50), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_idx   = idx;
        hit = 1'b1;
        for (int i = 0; i < K; i++) begin
            ix  = int'(idx[i*IDX_W +: IDX_W]);
            hit = hit & ((ix < M) ? model_bits[ix] : 1'b0);
            if (op == OP_INSERT && ix < M) model_bits[ix] = 1'b1;
        end
        exp_q.push_back(hit);
        if (op == OP_INSERT && model_count != '1) model_count = model_count + 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // Called right after send(). clr_at >= 0 pulses clear during that probe
    // cycle; hold stalls rsp_ready for that many cycles once rsp_valid is up.
    task automatic get_response(input int clr_at, input int hold);
        int   lat;
        logic expv;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            clear = (lat == clr_at);
            step();
            lat++;
        end
        clear = 1'b0;
        check("rsp_latency", 32'(lat), 32'(K));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            expv = 1'b0;
        end else begin
            expv = exp_q.pop_front();
        end
        check("rsp_hit", 32'(rsp_hit), 32'(expv));
        check("insert_count", 32'(insert_count), 32'(model_count));
        for (int c = 0; c < hold; c++) begin
            step();
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_hit", 32'(rsp_hit), 32'(expv));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        if (clr_at >= 0) begin
            check("clear_follows_busy", 32'(busy), 32'd1);
            check("clear_follows_ready", 32'(req_ready), 32'd0);
            model_bits  = '0;
            model_count = '0;
            step();
            check("after_clear_ready", 32'(req_ready), 32'd1);
            check("after_clear_count", 32'(insert_count), 32'd0);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("clear_blocks_ready", 32'(req_ready), 32'd0);
        step();
        clear = 1'b0;
        check("clear_state_busy", 32'(busy), 32'd1);
        step();
        model_bits  = '0;
        model_count = '0;
        check("clear_done_ready", 32'(req_ready), 32'd1);
        check("clear_done_count", 32'(insert_count), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_QUERY;
        req_idx   = '0;
        clear     = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_hit", 32'(rsp_hit), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_count", 32'(insert_count), 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] insert then query the same indices");
        send(OP_INSERT, pack4(3, 17, 200, 255));
        get_response(-1, 0);
        send(OP_QUERY, pack4(3, 17, 200, 255));
        get_response(-1, 0);
        send(OP_QUERY, pack4(3, 17, 200, 254));
        get_response(-1, 0);

        $display("[TB] duplicate indices on an empty filter");
        do_clear();
        send(OP_INSERT, pack4(9, 9, 9, 9));
        get_response(-1, 0);
        send(OP_QUERY, pack4(9, 9, 9, 9));
        get_response(-1, 0);

        $display("[TB] clear pulsed during probe");
        send(OP_INSERT, pack4(3, 17, 200, 255));
        get_response(1, 0);
        send(OP_QUERY, pack4(3, 17, 200, 255));
        get_response(-1, 0);
        send(OP_QUERY, pack4(9, 9, 9, 9));
        get_response(-1, 0);

        $display("[TB] response stalled for 10 cycles");
        send(OP_INSERT, pack4(1, 2, 3, 4));
        get_response(-1, 10);
        send(OP_QUERY, pack4(4, 3, 2, 1));
        get_response(-1, 3);

        $display("[TB] reset asserted mid-probe");
        send(OP_INSERT, pack4(50, 60, 70, 80));
        step();
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_hit", 32'(rsp_hit), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(insert_count), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        clear = 1'b1;
        #1;
        check("midrst_ready_follows_clear", 32'(req_ready), 32'd0);
        clear = 1'b0;
        exp_q.delete();
        model_bits  = '0;
        model_count = '0;
        step();
        rst = 1'b0;
        step();
        send(OP_QUERY, pack4(50, 60, 70, 80));
        get_response(-1, 0);
        send(OP_QUERY, pack4(1, 2, 3, 4));
        get_response(-1, 0);

        $display("[TB] insert counter saturation");
        for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
            send(OP_INSERT, pack4($urandom_range(0, M - 1), $urandom_range(0, M - 1),
                                  $urandom_range(0, M - 1), $urandom_range(0, M - 1)));
            get_response(-1, 0);
            if (n == (1 << CNT_W) - 2) begin
                check("count_reaches_max", 32'(insert_count), 32'((1 << CNT_W) - 1));
            end
        end
        check("count_saturated", 32'(insert_count), 32'((1 << CNT_W) - 1));
        send(OP_QUERY, pack4(0, 128, 64, 255));
        get_response(-1, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
